// File: rtl/alu_dispatch_arbiter_pkg.sv
// alu_dispatch_arbiter_pkg: opcodes, pop FSM states and tag type shared by the dispatch arbiter
package alu_dispatch_arbiter_pkg;
  localparam int DEPTH_DEF = 64;
  localparam int OCC_W = 7;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3, OP_AND = 4'h4;
  localparam logic [3:0] OP_OR = 4'h5, OP_XOR = 4'h6, OP_LS = 4'h7, OP_RS = 4'h8;
  typedef logic [11:0] instr_t;
  typedef logic tag_t;
  localparam tag_t TAG_A = 1'b0, TAG_B = 1'b1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_FIFO, WAIT_ALU, CAPTURE} state_e;
endpackage

// File: rtl/alu_dispatch_arbiter_if.sv
// alu_dispatch_arbiter_if: requester handshakes, FIFO strobes, ALU result and tagged result bus
interface alu_dispatch_arbiter_if;
  import alu_dispatch_arbiter_pkg::*;
  logic a_valid, a_ready, b_valid, b_ready;
  instr_t a_instr, b_instr, fifo_din;
  logic fifo_wr_en, fifo_rd_en;
  logic [7:0] alu_result, res_data;
  logic res_valid, err_divz;
  tag_t res_tag;
  logic [OCC_W-1:0] occupancy;
  modport slave (
    input a_valid, a_instr, b_valid, b_instr, alu_result,
    output a_ready, b_ready, fifo_wr_en, fifo_din, fifo_rd_en, res_valid, res_data, res_tag, occupancy, err_divz
  );
  modport master (
    output a_valid, a_instr, b_valid, b_instr, alu_result,
    input a_ready, b_ready, fifo_wr_en, fifo_din, fifo_rd_en, res_valid, res_data, res_tag, occupancy, err_divz
  );
endinterface

// File: rtl/alu_dispatch_arbiter_dispatch_tag_queue.sv
// dispatch_tag_queue: DEPTH x 1-bit requester-ID FIFO kept in lockstep with the external instruction FIFO
module dispatch_tag_queue
  import alu_dispatch_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  tag_t din_i,
  input  logic pop_i,
  output tag_t dout_o
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  assign wr_d = !push_i ? wr_q : wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
  assign rd_d = !pop_i ? rd_q : rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/alu_dispatch_arbiter.sv
// alu_dispatch_arbiter: round-robin push arbiter and single-in-flight pop sequencer for the shared FIFO + ALU.
// Optional ALU_DIVZERO_TRAP_EN drops divide-by-zero instructions at the push side and pulses err_divz.
module alu_dispatch_arbiter
  import alu_dispatch_arbiter_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int FIFO_LAT = 1,
  parameter int ALU_LAT  = 1
) (
  input logic clk,
  input logic rst,
  alu_dispatch_arbiter_if.slave bus
);
  localparam logic [7:0] FL = 8'(FIFO_LAT - 1);
  localparam logic [7:0] AL = 8'(ALU_LAT - 1);
  state_e state_q;
  logic rr_q, rr_d, rd_en_q, res_valid_q;
  tag_t tag_q, res_tag_q, tq_dout;
  logic [7:0] res_data_q, cnt_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic can, sel_b, grant, divz, push, avail;
  instr_t instr;
  assign can = rst && occ_q < OCC_W'(DEPTH);
  assign sel_b = bus.b_valid && (!bus.a_valid || rr_q);
  assign grant = can && (bus.a_valid || bus.b_valid);
  assign instr = sel_b ? bus.b_instr : bus.a_instr;
`ifdef ALU_DIVZERO_TRAP_EN
  assign divz = grant && instr[11:8] == OP_DIV && instr[3:0] == 4'h0;
`else
  assign divz = 1'b0;
`endif
  assign push = grant && !divz;
  // a push in this cycle is readable from the FIFO next cycle, so it can start a pop right away
  assign avail = occ_q != '0 || push;
  assign rr_d = grant && bus.a_valid && bus.b_valid ? !rr_q : rr_q;
  assign occ_d = occ_q + OCC_W'(push) - OCC_W'(rd_en_q);
  assign bus.a_ready = grant && !sel_b;
  assign bus.b_ready = grant && sel_b;
  assign bus.fifo_wr_en = push;
  assign bus.fifo_din = push ? instr : '0;
  assign bus.fifo_rd_en = rd_en_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data = res_data_q;
  assign bus.res_tag = res_tag_q;
  assign bus.occupancy = occ_q;
  assign bus.err_divz = divz;
  dispatch_tag_queue #(.DEPTH(DEPTH)) u_tag_queue (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (sel_b),
    .pop_i  (rd_en_q),
    .dout_o (tq_dout)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_tag_q <= TAG_A;
      tag_q <= TAG_A;
      cnt_q <= '0;
      occ_q <= '0;
      rr_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      rr_q <= rr_d;
      rd_en_q <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE, CAPTURE: begin
          state_q <= avail ? ISSUE : IDLE;
          rd_en_q <= avail;
        end
        ISSUE: begin
          tag_q <= tq_dout;
          state_q <= WAIT_FIFO;
        end
        WAIT_FIFO: begin
          cnt_q <= cnt_q == FL ? '0 : cnt_q + 8'd1;
          if (cnt_q == FL) state_q <= WAIT_ALU;
        end
        WAIT_ALU: begin
          cnt_q <= cnt_q == AL ? '0 : cnt_q + 8'd1;
          if (cnt_q == AL) begin
            state_q <= CAPTURE;
            res_valid_q <= 1'b1;
            res_data_q <= bus.alu_result;
            res_tag_q <= tag_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_dispatch_arbiter.sv
// tb_alu_dispatch_arbiter: random traffic against a timing-level reference model with a result scoreboard
module tb_alu_dispatch_arbiter;
  import alu_dispatch_arbiter_pkg::*;
`ifdef ALU_DIVZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  alu_dispatch_arbiter_if bus ();
  alu_dispatch_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {int cyc; logic tag; logic [7:0] data;} exp_t;
  exp_t sbq[$];
  int pend[$];
  logic [11:0] fq[$];
  logic [11:0] fdout = '0;
  int cyc = 0, last_res = -100, ncmp = 0, nerr = 0, full_seen = 0, occ_m = 0, r = 0;
  bit rr_m = 1'b0, take_b, gnt, dz;
  logic [11:0] ins;
  exp_t e;

  function automatic logic [7:0] alu(input logic [11:0] i);
    logic [7:0] a = {4'h0, i[7:4]};
    logic [7:0] b = {4'h0, i[3:0]};
    case (i[11:8])
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_MUL: return a * b;
      OP_DIV: return b == 8'h0 ? 8'hff : a / b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_LS:  return a << b;
      OP_RS:  return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [11:0] rnd();
    logic [3:0] op = 4'($urandom_range(0, 8));
    logic [3:0] b = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom);
    return {op, 4'($urandom), b};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    while (sbq.size() != 0 && n < 600) begin
      step();
      n++;
    end
    ncmp++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d results still outstanding after %0d cycles", sbq.size(), n);
    end
    repeat (2) step();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // external FIFO (1-cycle read) and ALU (1-cycle result)
  always @(posedge clk) begin
    if (!rst) fq.delete();
    else begin
      if (bus.fifo_rd_en) fdout <= fq.size() != 0 ? fq.pop_front() : 12'hxxx;
      if (bus.fifo_wr_en) fq.push_back(bus.fifo_din);
    end
    bus.alu_result <= alu(fdout);
  end

  // reference model: results every 4 cycles at best, each at least 4 cycles after its grant;
  // an entry stops counting toward occupancy 2 cycles before its result
  always @(negedge clk) begin
    if (!rst) begin
      sbq.delete();
      pend.delete();
      last_res = -100;
      rr_m = 1'b0;
    end else begin
      while (pend.size() != 0 && pend[0] <= cyc) void'(pend.pop_front());
      occ_m = 0;
      foreach (pend[k]) if (pend[k] - 2 > cyc) occ_m++;
      chk("occupancy", 32'(bus.occupancy), occ_m);
      if (occ_m == 64) full_seen++;
      take_b = (bus.a_valid && bus.b_valid) ? rr_m : bus.b_valid;
      gnt = occ_m < 64 && (bus.a_valid || bus.b_valid);
      ins = take_b ? bus.b_instr : bus.a_instr;
      dz = TRAP && gnt && ins[11:8] == 4'h3 && ins[3:0] == 4'h0;
      chk("a_ready", 32'(bus.a_ready), 32'(gnt && !take_b));
      chk("b_ready", 32'(bus.b_ready), 32'(gnt && take_b));
      chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(gnt && !dz));
      chk("err_divz", 32'(bus.err_divz), 32'(dz));
      if (gnt && !dz) begin
        chk("fifo_din", 32'(bus.fifo_din), 32'(ins));
        r = (cyc + 4 > last_res + 4) ? cyc + 4 : last_res + 4;
        last_res = r;
        pend.push_back(r);
        sbq.push_back('{r, take_b, alu(ins)});
      end
      if (gnt && bus.a_valid && bus.b_valid) rr_m = !rr_m;
    end
  end

  // monitor: every result pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.res_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL res_valid at cycle %0d: got unexpected result %0h tag %0d", cyc, bus.res_data, bus.res_tag);
      end else begin
        e = sbq.pop_front();
        chk("res_cycle", cyc, e.cyc);
        chk("res_tag", 32'(bus.res_tag), 32'(e.tag));
        chk("res_data", 32'(bus.res_data), 32'(e.data));
      end
    end
  end

  initial begin
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_instr = '0;
    bus.b_instr = '0;
    repeat (3) step();
    chk("reset occupancy", 32'(bus.occupancy), 0);
    chk("reset res_valid", 32'(bus.res_valid), 0);
    chk("reset fifo_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("reset fifo_wr_en", 32'(bus.fifo_wr_en), 0);
    rst = 1'b1;
    step();
    bus.a_valid = 1'b1;
    bus.a_instr = 12'h012;
    step();
    bus.a_valid = 1'b0;
    repeat (6) step();
    bus.a_valid = 1'b1;
    bus.a_instr = 12'h350;
    step();
    bus.a_valid = 1'b0;
    repeat (6) step();
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a_instr = rnd();
      bus.b_instr = rnd();
      step();
    end
    drain();
    for (int i = 0; i < 200; i++) begin
      bus.a_valid = $urandom % 4 == 0;
      bus.b_valid = $urandom % 4 == 0;
      bus.a_instr = rnd();
      bus.b_instr = rnd();
      step();
    end
    for (int i = 0; i < 300; i++) begin
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      bus.a_instr = rnd();
      bus.b_instr = rnd();
      step();
    end
    drain();
    bus.b_valid = 1'b1;
    bus.b_instr = 12'h0a5;
    step();
    bus.b_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("midpop occupancy", 32'(bus.occupancy), 0);
    chk("midpop res_valid", 32'(bus.res_valid), 0);
    chk("midpop fifo_rd_en", 32'(bus.fifo_rd_en), 0);
    rst = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 200; i++) begin
      bus.a_valid = $urandom % 2 == 0;
      bus.b_valid = $urandom % 3 == 0;
      bus.a_instr = rnd();
      bus.b_instr = rnd();
      step();
    end
    drain();
    chk("full reached", 32'(full_seen != 0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
